// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
//
// Purpose:
//   Bundles the request and result signals exchanged between the control unit
//   and the sequential divider. Clock and reset are not part of the bundle and
//   stay as plain module ports.
//
// Signals (BITS = operand / result width):
//   start        control -> divider  request a divide (sampled only when idle)
//   signed_op    control -> divider  1 = two's-complement, 0 = unsigned
//   a            control -> divider  dividend, captured at the accepting edge
//   b            control -> divider  divisor, captured at the accepting edge
//   busy         divider -> control  high while an operation is in flight
//   done         divider -> control  one-cycle pulse when hi/lo become valid
//   div_by_zero  divider -> control  set with done when b was zero
//   hi           divider -> control  remainder
//   lo           divider -> control  quotient
//
// Modports:
//   master  the control side (drives the request, observes the result)
//   slave   the divider side (observes the request, drives the result)
// -----------------------------------------------------------------------------
interface seq_divider_if #(
  parameter int BITS = 32
);

  logic            start;
  logic            signed_op;
  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [BITS-1:0] hi;
  logic [BITS-1:0] lo;

  modport master (
    output start,
    output signed_op,
    output a,
    output b,
    input  busy,
    input  done,
    input  div_by_zero,
    input  hi,
    input  lo
  );

  modport slave (
    input  start,
    input  signed_op,
    input  a,
    input  b,
    output busy,
    output done,
    output div_by_zero,
    output hi,
    output lo
  );

endinterface

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Purpose:
//   Multicycle radix-2 restoring divider. It works on operand magnitudes and
//   applies signs in a final fix-up cycle. The quotient is returned on lo and
//   the remainder on hi. Signed division truncates toward zero and the
//   remainder takes the sign of the dividend, so a = q*b + r holds.
//
//   Sequence: IDLE -(start)-> ITER (BITS edges) -> FIX (1 edge) -> IDLE.
//   If the accepting edge is E0, done is registered at edge E0+BITS+1.
//
//   Division by zero still runs the full iteration so latency does not
//   change, but the result is forced: lo = all ones and hi = original a.
//
// Ports:
//   clk    rising-edge clock
//   clr_n  asynchronous active-low reset; abandons any division in flight
//   bus    seq_divider_if.slave: start/signed_op/a/b in,
//          busy/done/div_by_zero/hi/lo out
//
// Parameters:
//   BITS   operand, quotient and remainder width
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int BITS = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  seq_divider_if.slave bus
);

  // Counter width large enough to hold BITS-1.
  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t          state_reg;
  state_t          state_next;

  logic [CW-1:0]   cnt_reg;       // number of ITER edges already taken
  logic [BITS-1:0] rem_reg;       // partial remainder
  logic [BITS-1:0] quot_reg;      // dividend bits shift out, quotient bits shift in
  logic [BITS-1:0] div_reg;       // divisor magnitude
  logic [BITS-1:0] a_raw_reg;     // original dividend, returned on divide by zero
  logic            sign_q_reg;    // negate the quotient in FIX
  logic            sign_r_reg;    // negate the remainder in FIX
  logic            zero_reg;      // divisor was zero at accept

  // Registered outputs
  logic            busy_reg;
  logic            busy_next;
  logic            done_reg;
  logic            done_next;
  logic            dbz_reg;
  logic            dbz_next;
  logic [BITS-1:0] hi_reg;
  logic [BITS-1:0] hi_next;
  logic [BITS-1:0] lo_reg;
  logic [BITS-1:0] lo_next;

  // ---------------------------------------------------------------------------
  // Decodes
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            last_iter;

  assign accept    = (state_reg == IDLE) && bus.start;
  assign last_iter = (state_reg == ITER) && (cnt_reg == CW'(BITS - 1));

  // ---------------------------------------------------------------------------
  // Operand magnitudes. Negation wraps at BITS bits, so the most negative
  // value maps onto itself and is then treated as an unsigned magnitude.
  // ---------------------------------------------------------------------------
  logic [BITS-1:0] a_mag;
  logic [BITS-1:0] b_mag;

  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
    if (bus.signed_op && bus.a[BITS-1]) begin
      a_mag = -bus.a;
    end
    if (bus.signed_op && bus.b[BITS-1]) begin
      b_mag = -bus.b;
    end
  end

  // ---------------------------------------------------------------------------
  // One restoring step. The shifted remainder needs BITS+1 bits: the partial
  // remainder is always below the divisor, so after the shift it is below
  // twice the divisor and the top bit of the trial difference is a valid
  // borrow/sign indicator.
  // ---------------------------------------------------------------------------
  logic [BITS:0]   shifted;
  logic [BITS:0]   trial;
  logic            trial_ok;

  always_comb begin
    shifted  = {rem_reg, quot_reg[BITS-1]};
    trial    = shifted - {1'b0, div_reg};
    trial_ok = ~trial[BITS];
  end

  // Sign fix-up of the magnitude results.
  logic [BITS-1:0] quot_signed;
  logic [BITS-1:0] rem_signed;

  always_comb begin
    quot_signed = sign_q_reg ? -quot_reg : quot_reg;
    rem_signed  = sign_r_reg ? -rem_reg  : rem_reg;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = ITER;
        end
      end
      ITER: begin
        if (last_iter) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic. done defaults low so it can only ever be a single-cycle
  // pulse; a start arriving in the done cycle is accepted from IDLE and the
  // pulse still drops on that edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_next = busy_reg;
    done_next = 1'b0;
    dbz_next  = dbz_reg;
    hi_next   = hi_reg;
    lo_next   = lo_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          busy_next = 1'b1;
          dbz_next  = 1'b0;
        end
      end
      ITER: begin
        busy_next = 1'b1;
      end
      FIX: begin
        busy_next = 1'b0;
        done_next = 1'b1;
        dbz_next  = zero_reg;
        if (zero_reg) begin
          lo_next = '1;
          hi_next = a_raw_reg;
        end else begin
          lo_next = quot_signed;
          hi_next = rem_signed;
        end
      end
      default: begin
        busy_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
      hi_reg   <= '0;
      lo_reg   <= '0;
    end else begin
      busy_reg <= busy_next;
      done_reg <= done_next;
      dbz_reg  <= dbz_next;
      hi_reg   <= hi_next;
      lo_reg   <= lo_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_reg    <= '0;
      rem_reg    <= '0;
      quot_reg   <= '0;
      div_reg    <= '0;
      a_raw_reg  <= '0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_reg    <= '0;
        rem_reg    <= '0;
        quot_reg   <= a_mag;
        div_reg    <= b_mag;
        a_raw_reg  <= bus.a;
        sign_q_reg <= bus.signed_op & (bus.a[BITS-1] ^ bus.b[BITS-1]);
        sign_r_reg <= bus.signed_op & bus.a[BITS-1];
        zero_reg   <= (bus.b == '0);
      end else if (state_reg == ITER) begin
        cnt_reg  <= cnt_reg + CW'(1);
        quot_reg <= {quot_reg[BITS-2:0], trial_ok};
        rem_reg  <= trial_ok ? trial[BITS-1:0] : shifted[BITS-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Self-checking bench for seq_divider (BITS = 32). Directed and random divides
// are compared against a 64-bit arithmetic reference; handshake timing,
// start-while-busy, back-to-back start and asynchronous reset are checked.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int BITS = 32;
  localparam int LAT  = 34;   // negedge sample index of done, accept sample = 1
  localparam int BUSY = 33;   // cycles with busy high

  logic clk = 1'b0;
  logic clr_n;

  always #5 clk = ~clk;

  seq_divider_if #(.BITS(BITS)) bus ();

  seq_divider #(.BITS(BITS)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit integer division (truncating toward zero in SV).
  // Widening avoids the -2^31 / -1 overflow; its low 32 bits give the wrap.
  function automatic void ref_div(input logic [31:0] ra, input logic [31:0] rb,
                                  input logic rs, output logic [31:0] q,
                                  output logic [31:0] r, output logic dz);
    longint la, lb, lq, lr;
    if (rb == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = ra;
      dz = 1'b1;
    end else begin
      la = rs ? {{32{ra[31]}}, ra} : {32'd0, ra};
      lb = rs ? {{32{rb[31]}}, rb} : {32'd0, rb};
      lq = la / lb;
      lr = la % lb;
      q  = lq[31:0];
      r  = lr[31:0];
      dz = 1'b0;
    end
  endfunction

  // Drive a request at the current negedge; returns at the first negedge
  // after the accepting edge, with inputs scrambled.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tbv, input logic ts);
    bus.start     = 1'b1;
    bus.a         = ta;
    bus.b         = tbv;
    bus.signed_op = ts;
    @(posedge clk);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.signed_op = 1'($urandom_range(0, 1));
    chk("accept_busy", 64'(bus.busy), 64'd1);
    chk("accept_done_low", 64'(bus.done), 64'd0);
    chk("accept_dbz_clear", 64'(bus.div_by_zero), 64'd0);
  endtask

  // Wait (bounded) for done; lat = negedge sample index where done was seen.
  task automatic wait_done(input bit inject, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 1;
    for (int n = 2; n <= 60; n++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (inject && n == 9) begin
        bus.start     = 1'b1;
        bus.a         = $urandom;
        bus.b         = 32'($urandom_range(1, 9));
        bus.signed_op = 1'($urandom_range(0, 1));
      end
      if (inject && n == 10) bus.start = 1'b0;
    end
  endtask

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                       input bit inject, input bit chain);
    logic [31:0] eq, er;
    logic        edz;
    int          lat, bcnt;
    ref_div(ta, tbv, ts, eq, er, edz);
    start_op(ta, tbv, ts);
    wait_done(inject, lat, bcnt);
    chk("latency", 64'(lat), 64'(LAT));
    chk("busy_cycles", 64'(bcnt), 64'(BUSY));
    chk("lo", 64'(bus.lo), 64'(eq));
    chk("hi", 64'(bus.hi), 64'(er));
    chk("div_by_zero", 64'(bus.div_by_zero), 64'(edz));
    $display("op a=%h b=%h signed=%0d lo=%h hi=%h dbz=%0d lat=%0d", ta, tbv, ts,
             bus.lo, bus.hi, bus.div_by_zero, lat);
    if (!chain) begin
      @(negedge clk);
      chk("done_width", 64'(bus.done), 64'd0);
      chk("lo_hold", 64'(bus.lo), 64'(eq));
      chk("hi_hold", 64'(bus.hi), 64'(er));
      chk("dbz_hold", 64'(bus.div_by_zero), 64'(edz));
    end
  endtask

  initial begin
    int          dcount;
    logic [31:0] ra, rb;
    int          sel;

    clr_n         = 1'b0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    clr_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_op(32'd124,        32'd7,          1'b1, 1'b0, 1'b0);
    do_op(32'hFFFF_FF84,  32'd7,          1'b1, 1'b0, 1'b0);
    do_op(32'd124,        32'hFFFF_FFF9,  1'b1, 1'b0, 1'b0);
    do_op(32'hFFFF_FF84,  32'hFFFF_FFF9,  1'b1, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF,  32'd2,          1'b0, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF,  32'd2,          1'b1, 1'b0, 1'b0);
    do_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0);
    do_op(32'h0000_007C,  32'd0,          1'b1, 1'b0, 1'b0);
    do_op(32'hFFFF_FF00,  32'd0,          1'b0, 1'b0, 1'b0);
    do_op(32'd1000,       32'd33,         1'b0, 1'b0, 1'b0);  // dbz clears

    // Random cases
    for (int i = 0; i < 24; i++) begin
      sel = int'($urandom_range(0, 7));
      ra  = (sel == 7) ? 32'h8000_0000 : $urandom;
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      do_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // Start while busy is ignored
    do_op(32'd1000, 32'd7, 1'b0, 1'b1, 1'b0);

    // Start in the done cycle: back-to-back
    do_op(32'd124, 32'd7, 1'b1, 1'b0, 1'b1);
    do_op(32'hFFFF_FC18, 32'd13, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-ITER
    start_op(32'hDEAD_BEEF, 32'd3, 1'b0);
    repeat (13) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    clr_n  = 1'b1;
    dcount = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    chk("no_done_after_reset", 64'(dcount), 64'd0);
    do_op(32'd124, 32'd7, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multicycle radix-2 restoring divider. It is the inverse datapath to the ALU's combinational Booth multiplier.
- Produces the quotient on lo and the remainder on hi, the same hi/lo split the ALU uses for mul.
- Sits beside the ALU and is driven by the control unit for the div instruction.
- Handshake: start/busy/done, so control stalls until the result is ready.

Parameters:
- BITS, 32, operand, quotient and remainder width.

Ports:
- clk  input  1  rising-edge clock
- clr_n  input  1  asynchronous active-low reset
- start  input  1  request a divide; sampled only when idle
- signed_op  input  1  1 = two's-complement divide, 0 = unsigned divide
- a  input  BITS  dividend, captured at the accepting edge
- b  input  BITS  divisor, captured at the accepting edge
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when hi/lo become valid
- div_by_zero  output  1  set with done when b was zero; held until the next accept
- hi  output  BITS  remainder
- lo  output  BITS  quotient

Behaviour:
- Reset (clr_n low, asynchronous):
  - busy, done, div_by_zero, hi, lo all become 0.
  - State goes to IDLE and the iteration counter clears.
  - Reset mid-operation abandons the division; no done is produced.
- States: IDLE -> ITER -> FIX -> IDLE.
- IDLE:
  - On an edge with start=1, latch sign_q = signed_op & (a[BITS-1] ^ b[BITS-1]) and sign_r = signed_op & a[BITS-1].
  - Latch |a| and |b|: absolute values when signed_op=1, raw values otherwise.
  - Clear the partial remainder and counter, latch zero flag = (b==0).
  - busy goes to 1, done goes to 0, state goes to ITER.
- ITER: one quotient bit per edge, MSB first.
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor from rem, using a BITS+1 bit subtraction so no carry is lost.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the quotient bit to 0.
  - After exactly BITS ITER edges, state goes to FIX.
- FIX (one edge):
  - lo = sign_q ? -quot : quot.
  - hi = sign_r ? -rem : rem.
  - div_by_zero = zero flag.
  - done goes to 1, busy goes to 0, state goes to IDLE.
- Latency: the accepting edge is E0 and done is registered at edge E0+BITS+1. For BITS=32, done is high during the 34th cycle counting the accept cycle as 1.
- Output hold: done is high for exactly one cycle. hi, lo and div_by_zero hold their values until the next accept.
- Signed rounding: quotient truncates toward zero; remainder takes the sign of the dividend, so a = q*b + r holds.
- Divide by zero:
  - Result is forced, not computed: lo = all ones and hi = a (the original dividend), regardless of signed_op.
  - div_by_zero = 1.
  - Latency is unchanged.
- Signed overflow: -2^(BITS-1) / -1 gives lo = 0x80000000 (wraps) and hi = 0, with no flag. Magnitudes use BITS-bit wrapping negation, so |0x80000000| is treated as unsigned 0x80000000.
- Start while busy: ignored; the operands in flight are unaffected.
- Start in the same cycle done is high: accepted, since state is IDLE. done drops on that edge and the new operation begins.
- a and b may change freely after the accepting edge.

Test Plan:
- Signed positive, signed_op=1, a=124, b=7 -> after 34 cycles done pulses once; lo=17, hi=5, div_by_zero=0. busy is high for exactly 33 cycles.
- Signed negative:
  - a=-124, b=7 -> lo=0xFFFFFFEF (-17), hi=0xFFFFFFFB (-5).
  - a=124, b=-7 -> lo=-17, hi=5.
  - a=-124, b=-7 -> lo=17, hi=-5.
- Unsigned, signed_op=0:
  - a=0xFFFFFFFF, b=2 -> lo=0x7FFFFFFF, hi=1.
  - Same operands with signed_op=1 -> lo=0, hi=0xFFFFFFFF.
- Corner cases:
  - a=0x80000000, b=0xFFFFFFFF, signed -> lo=0x80000000, hi=0.
  - b=0, a=0x0000007C -> lo=0xFFFFFFFF, hi=0x0000007C, div_by_zero=1; flag clears on the next accept.
- Handshake:
  - Pulse start again at cycle 10 with different operands -> ignored; original result returned.
  - Assert start during the done cycle -> second result arrives exactly 34 cycles later, with no lost or duplicate done.
- Reset: drop clr_n mid-ITER (cycle 15) asynchronously -> busy, done, hi, lo are 0 immediately; no done follows. A fresh start after release divides correctly.
